mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Sequencing controller that shares one single-port, multi-cycle unified memory between the instruction-fetch (IF) stage and the data-memory (MEM) stage of the ARM pipeline. It grants one requester at a time, holds the memory request stable for a fixed access latency, and returns read data with a one-cycle ready pulse. Requesters stall their stage until they see ready.

## Interface
- `ADDR_W`, 32, byte address width.
- `DATA_W`, 32, data width; equals `INSTRUCTION_LEN`.
- `MEM_LAT`, 4, memory access cycles, ≥1.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `if_req`  in  1  IF read request; held until `if_ready`.
- `if_addr`  in  ADDR_W  fetch address (PC).
- `if_rdata`  out  DATA_W  fetched instruction.
- `if_ready`  out  1  one-cycle pulse, IF transfer complete.
- `mem_rd`  in  1  MEM read request; held until `mem_ready`.
- `mem_wr`  in  1  MEM write request; held until `mem_ready`.
- `mem_addr`  in  ADDR_W  data address.
- `mem_wdata`  in  DATA_W  store data.
- `mem_rdata`  out  DATA_W  load data.
- `mem_ready`  out  1  one-cycle pulse, MEM transfer complete.
- `ram_en`  out  1  memory access enable.
- `ram_we`  out  1  memory write enable.
- `ram_addr`  out  ADDR_W  memory address.
- `ram_wdata`  out  DATA_W  memory write data.
- `ram_rdata`  in  DATA_W  memory read data, valid `MEM_LAT` cycles after `ram_en` rises with stable inputs.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if `mem_rd|mem_wr`, grant MEM. Otherwise, if `if_req`, grant IF. Otherwise stay.
- MEM has fixed priority over IF because it is the older instruction.
- On grant, latch owner, `ram_addr`, `ram_wdata` and `ram_we`, then go to ACCESS.
- `mem_wr` and `mem_rd` together is illegal. Write takes precedence.
- ACCESS: `ram_en`=1. Latched outputs stay frozen and requester inputs are ignored. The wait counter loads `MEM_LAT-1` on grant and decrements each cycle. When the counter is 0, capture `ram_rdata` into the owner's rdata register (reads only) and go to RESP.
- RESP: pulse the owner's ready for one cycle, then go to IDLE.
- On a write, `mem_rdata` keeps its previous value and `mem_ready` still pulses.
- `if_rdata` and `mem_rdata` hold their value until the next read by the same owner.
- Requester obligation: drop or change its request on the edge at which ready is sampled high. IDLE then re-evaluates requests on the following cycle.
- Starvation: IF is served whenever MEM is idle. The pipeline guarantees MEM requests are finite.

## Timing
- Reset values:
  - State: IDLE.
  - `ram_en`, `ram_we`, `if_ready`, `mem_ready`, `busy`: 0.
  - `ram_addr`, `ram_wdata`, `if_rdata`, `mem_rdata`: 0.
- Latency: request sampled in IDLE at cycle t; ACCESS occupies t+1..t+MEM_LAT; ready is high at t+MEM_LAT+1.
- Throughput: one transfer per MEM_LAT+2 cycles; back-to-back grants are separated by one IDLE cycle.
- MEM_LAT=1: ACCESS lasts one cycle and capture happens on that cycle.
- Requests arriving during ACCESS or RESP are not lost. They are sampled in the next IDLE.
- Reset mid-ACCESS: abort with no ready pulse and no rdata update. `ram_en`=0 the cycle after `rst`.
- Both ready outputs are never high in the same cycle.

## Structure
- Shared `defines.v`: `INSTRUCTION_LEN`, `MEM_LAT` default, state encodings (`ARB_IDLE`, `ARB_ACCESS`, `ARB_RESP`), owner encoding (`OWN_IF`, `OWN_MEM`).
- Single module, no sub-module. The wait counter is inline, `$clog2(MEM_LAT+1)` bits wide.
- The testbench memory model returns data exactly `MEM_LAT` cycles after `ram_en` rises.

## Test plan
- IF only: RAM[0]=0xE3A00014, `if_req`=1, `if_addr`=0 at cycle 1 → `ram_en` high on cycles 2–5; `if_ready` pulse on cycle 6 with `if_rdata`=0xE3A00014.
- Contention: `if_req` and `mem_rd` (`mem_addr`=1024, RAM[1024]=8192) both rise at cycle 1 → MEM served first, `mem_ready` on cycle 6 with `mem_rdata`=8192; IF granted cycle 7, `if_ready` on cycle 12.
- Write: `mem_wr`, `mem_addr`=1028, `mem_wdata`=0xC0000000 → `ram_we`=1 for 4 cycles, RAM[1028]=0xC0000000, `mem_ready` pulses, `mem_rdata` unchanged.
- Input change during ACCESS: toggle `mem_addr` from 1024 to 1040 mid-access → `ram_addr` stays 1024; returned data is RAM[1024].
- Reset at ACCESS cycle 2 → no ready pulse, `ram_en`=0 next cycle, `busy`=0; a fresh `if_req` completes normally.
- MEM_LAT=1 build: IF read completes with `if_ready` at t+2; back-to-back IF reads complete every 3 cycles.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
// Shared types and constants for the IF/MEM unified-memory arbiter.
//   arb_state_t  : sequencing FSM states (IDLE, ACCESS, RESP)
//   arb_owner_t  : which pipeline stage currently owns the memory
//   INSTRUCTION_LEN, MEM_LAT_DEFAULT : datapath width and default access latency
package mem_arbiter_pkg;

    localparam int INSTRUCTION_LEN = 32;
    localparam int MEM_LAT_DEFAULT = 4;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_RESP   = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } arb_owner_t;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one single-port, multi-cycle memory between the instruction-fetch
// stage and the data-memory stage. One requester is granted at a time, the
// memory request is held frozen for MEM_LAT cycles, and the owner sees a
// one-cycle ready pulse with its read data.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   if_req, if_addr                  IF read request / fetch address
//   if_rdata, if_ready               fetched instruction / completion pulse
//   mem_rd, mem_wr, mem_addr,        MEM load/store request, address,
//   mem_wdata                        store data
//   mem_rdata, mem_ready             load data / completion pulse
//   ram_en, ram_we, ram_addr,        memory-side request (frozen in ACCESS)
//   ram_wdata
//   ram_rdata                        memory read data
//   busy                             high whenever the FSM is not IDLE
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = INSTRUCTION_LEN,
    parameter int MEM_LAT = MEM_LAT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);

    localparam int               CNT_W    = $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    arb_state_t        r_state;
    arb_state_t        w_nextState;
    arb_owner_t        r_owner;
    logic [CNT_W-1:0]  r_waitCnt;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_ifRdata;
    logic [DATA_W-1:0] r_memRdata;
    logic              w_memReq;
    logic              w_grant;
    logic              w_grantMem;
    logic              w_capture;

    // Next-state and grant decode. MEM wins over IF in IDLE because it
    // belongs to the older instruction; IF is still served whenever MEM has
    // nothing pending. Requests are only looked at in IDLE, so anything that
    // shows up during ACCESS or RESP simply waits for the next IDLE cycle.
    always_comb begin
        w_memReq    = mem_rd | mem_wr;
        w_grant     = 1'b0;
        w_grantMem  = 1'b0;
        w_capture   = 1'b0;
        w_nextState = r_state;
        case (r_state)
            ARB_IDLE: begin
                if (w_memReq) begin
                    w_grant     = 1'b1;
                    w_grantMem  = 1'b1;
                    w_nextState = ARB_ACCESS;
                end else if (if_req) begin
                    w_grant     = 1'b1;
                    w_nextState = ARB_ACCESS;
                end
            end
            ARB_ACCESS: begin
                if (r_waitCnt == '0) begin
                    w_capture   = 1'b1;
                    w_nextState = ARB_RESP;
                end
            end
            ARB_RESP: begin
                w_nextState = ARB_IDLE;
            end
            default: begin
                w_nextState = ARB_IDLE;
            end
        endcase
    end

    // State register. Reset drops straight back to IDLE, which also kills an
    // in-flight access without ever reaching RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Request latch, wait counter and read-data capture. Everything the
    // memory sees is latched at grant so that requester inputs can wander
    // during ACCESS. The counter starts at MEM_LAT-1 so the capture lands on
    // the MEM_LAT-th ACCESS cycle. Writes leave both rdata registers alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner    <= OWN_IF;
            r_waitCnt  <= '0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_ifRdata  <= '0;
            r_memRdata <= '0;
        end else begin
            if (w_grant) begin
                r_owner   <= w_grantMem ? OWN_MEM : OWN_IF;
                r_waitCnt <= CNT_LOAD;
                r_we      <= w_grantMem & mem_wr;
                r_addr    <= w_grantMem ? mem_addr : if_addr;
                if (w_grantMem) begin
                    r_wdata <= mem_wdata;
                end
            end else if (r_state == ARB_ACCESS && r_waitCnt != '0) begin
                r_waitCnt <= r_waitCnt - CNT_ONE;
            end

            if (w_capture && !r_we) begin
                if (r_owner == OWN_MEM) begin
                    r_memRdata <= ram_rdata;
                end else begin
                    r_ifRdata <= ram_rdata;
                end
            end
        end
    end

    // Outputs are decoded from registered state only, so both ready pulses
    // are mutually exclusive by construction (one owner, one RESP cycle).
    assign ram_en    = (r_state == ARB_ACCESS);
    assign ram_we    = ram_en & r_we;
    assign ram_addr  = r_addr;
    assign ram_wdata = r_wdata;
    assign busy      = (r_state != ARB_IDLE);
    assign if_ready  = (r_state == ARB_RESP) && (r_owner == OWN_IF);
    assign mem_ready = (r_state == ARB_RESP) && (r_owner == OWN_MEM);
    assign if_rdata  = r_ifRdata;
    assign mem_rdata = r_memRdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Drives mem_arbiter (MEM_LAT=4) from a table of IF/MEM transactions plus a
// few hand-written multi-cycle sequences, and a second MEM_LAT=1 instance
// for back-to-back fetch timing. Expected responses are queued when a
// request is driven and compared when a ready pulse appears.
module tb_mem_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int LAT    = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;
    logic              mem_rd;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic              busy;

    // Second instance, MEM_LAT=1, IF side only
    logic              if_reqF;
    logic [ADDR_W-1:0] if_addrF;
    logic [DATA_W-1:0] if_rdataF;
    logic              if_readyF;
    logic              zeroF = 1'b0;
    logic [ADDR_W-1:0] zeroAddrF = '0;
    logic [DATA_W-1:0] zeroDataF = '0;
    logic [DATA_W-1:0] mem_rdataF;
    logic              mem_readyF;
    logic              ram_enF;
    logic              ram_weF;
    logic [ADDR_W-1:0] ram_addrF;
    logic [DATA_W-1:0] ram_wdataF;
    logic [DATA_W-1:0] ram_rdataF;
    logic              busyF;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .busy(busy)
    );

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(1)) dutFast (
        .clk(clk), .rst(rst),
        .if_req(if_reqF), .if_addr(if_addrF), .if_rdata(if_rdataF), .if_ready(if_readyF),
        .mem_rd(zeroF), .mem_wr(zeroF), .mem_addr(zeroAddrF), .mem_wdata(zeroDataF),
        .mem_rdata(mem_rdataF), .mem_ready(mem_readyF),
        .ram_en(ram_enF), .ram_we(ram_weF), .ram_addr(ram_addrF), .ram_wdata(ram_wdataF),
        .ram_rdata(ram_rdataF), .busy(busyF)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: data (and write commit) only on the LAT-th ram_en cycle
    logic [31:0] ram [0:2047];
    int          enCnt = 0;

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we && enCnt == LAT - 1) ram[ram_addr[12:2]] <= ram_wdata;
            enCnt <= enCnt + 1;
        end else begin
            enCnt <= 0;
        end
    end

    assign ram_rdata  = (ram_en && enCnt == LAT - 1) ? ram[ram_addr[12:2]] : 32'hDEADBEEF;
    assign ram_rdataF = ram_enF ? (ram_addrF ^ 32'hA5A50000) : 32'hDEADBEEF;

    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        bit          isMem;
        logic [31:0] data;
        int          readyCyc;
    } exp_t;

    exp_t sbq[$];
    int   enSeen = 0;
    int   weSeen = 0;

    // Response monitor: pops one expectation per ready pulse
    always @(negedge clk) begin
        exp_t e;
        if (ram_en === 1'b1) enSeen++;
        if (ram_we === 1'b1) weSeen++;
        if (if_ready === 1'b1 || mem_ready === 1'b1) begin
            checkOutput("ready exclusive", {31'b0, if_ready & mem_ready}, 32'd0);
            if (sbq.size() == 0) begin
                checkOutput("unexpected ready", {30'b0, if_ready, mem_ready}, 32'd0);
            end else begin
                e = sbq.pop_front();
                checkOutput("ready owner", {31'b0, mem_ready}, {31'b0, e.isMem});
                if (e.isMem) checkOutput("mem_rdata", mem_rdata, e.data);
                else         checkOutput("if_rdata", if_rdata, e.data);
                checkOutput("ready cycle", cyc, e.readyCyc);
            end
        end
    end

    typedef struct {
        bit          ifReq;
        bit          memRd;
        bit          memWr;
        logic [31:0] ifAddr;
        logic [31:0] memAddr;
        logic [31:0] wdata;
        logic [31:0] expIf;
        logic [31:0] expMem;
    } vec_t;

    vec_t vecs[7];

    task automatic applyStimulus(input vec_t v);
        int t;
        bit isMem;
        t     = cyc;
        isMem = v.memRd | v.memWr;
        if_req    = v.ifReq;
        if_addr   = v.ifAddr;
        mem_rd    = v.memRd;
        mem_wr    = v.memWr;
        mem_addr  = v.memAddr;
        mem_wdata = v.wdata;
        if (isMem) sbq.push_back('{isMem: 1'b1, data: v.expMem, readyCyc: t + LAT + 1});
        if (v.ifReq) sbq.push_back('{isMem: 1'b0, data: v.expIf,
                                     readyCyc: isMem ? t + 2 * LAT + 3 : t + LAT + 1});
    endtask

    // Plays the requesters: drop a request once its ready is seen
    task automatic serviceRequests(input int budget);
        int n;
        n = 0;
        while ((if_req || mem_rd || mem_wr || busy) && n < budget) begin
            @(negedge clk);
            n++;
            if (mem_ready) begin
                mem_rd = 1'b0;
                mem_wr = 1'b0;
            end
            if (if_ready) if_req = 1'b0;
        end
        if (if_req || mem_rd || mem_wr || busy) begin
            checkOutput("service timeout", 32'd1, 32'd0);
            if_req = 1'b0;
            mem_rd = 1'b0;
            mem_wr = 1'b0;
        end
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int e0;
        int w0;
        int t;
        int n;

        ram[0]   <= 32'hE3A00014;
        ram[1]   <= 32'hE59F1010;
        ram[2]   <= 32'hE2811001;
        ram[256] <= 32'h00002000;
        ram[257] <= 32'h00000000;
        ram[260] <= 32'h11112222;

        vecs[0] = '{1'b1, 1'b0, 1'b0, 32'd0, 32'd0,    32'd0,        32'hE3A00014, 32'd0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 32'd4, 32'd1024, 32'd0,        32'hE59F1010, 32'h00002000};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 32'd0, 32'd1028, 32'hC0000000, 32'd0,        32'h00002000};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 32'd0, 32'd1028, 32'd0,        32'd0,        32'hC0000000};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 32'd0, 32'd1040, 32'h5555AAAA, 32'd0,        32'hC0000000};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 32'd0, 32'd1040, 32'd0,        32'd0,        32'h5555AAAA};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 32'd8, 32'd0,    32'd0,        32'hE2811001, 32'd0};

        rst       = 1'b1;
        if_req    = 1'b0;
        if_addr   = '0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if_reqF   = 1'b0;
        if_addrF  = '0;

        repeat (3) @(negedge clk);
        checkOutput("reset ram_en",    {31'b0, ram_en},    32'd0);
        checkOutput("reset ram_we",    {31'b0, ram_we},    32'd0);
        checkOutput("reset if_ready",  {31'b0, if_ready},  32'd0);
        checkOutput("reset mem_ready", {31'b0, mem_ready}, 32'd0);
        checkOutput("reset busy",      {31'b0, busy},      32'd0);
        checkOutput("reset ram_addr",  ram_addr,  32'd0);
        checkOutput("reset ram_wdata", ram_wdata, 32'd0);
        checkOutput("reset if_rdata",  if_rdata,  32'd0);
        checkOutput("reset mem_rdata", mem_rdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Table-driven transactions
        for (int i = 0; i < 7; i++) begin
            e0 = enSeen;
            w0 = weSeen;
            applyStimulus(vecs[i]);
            serviceRequests(40);
            checkOutput("ram_en cycles", enSeen - e0,
                        LAT * (int'(vecs[i].ifReq) + int'(vecs[i].memRd | vecs[i].memWr)));
            checkOutput("ram_we cycles", weSeen - w0, vecs[i].memWr ? LAT : 0);
            if (vecs[i].memWr)
                checkOutput("ram write commit", ram[vecs[i].memAddr[12:2]], vecs[i].wdata);
        end

        // Requester address wanders during ACCESS; latched address must win
        t         = cyc;
        mem_rd    = 1'b1;
        mem_addr  = 32'd1024;
        sbq.push_back('{isMem: 1'b1, data: 32'h00002000, readyCyc: t + LAT + 1});
        @(negedge clk);
        @(negedge clk);
        mem_addr = 32'd1040;
        @(negedge clk);
        checkOutput("ram_addr frozen", ram_addr, 32'd1024);
        serviceRequests(40);

        // Reset during the second ACCESS cycle aborts the fetch
        if_req  = 1'b1;
        if_addr = 32'd0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("abort in access", {31'b0, ram_en}, 32'd1);
        rst    = 1'b1;
        if_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort ram_en", {31'b0, ram_en}, 32'd0);
        checkOutput("abort busy",   {31'b0, busy},   32'd0);
        repeat (LAT + 2) @(negedge clk);
        checkOutput("abort if_rdata", if_rdata, 32'd0);
        applyStimulus(vecs[0]);
        serviceRequests(40);

        checkOutput("scoreboard drained", sbq.size(), 32'd0);

        // MEM_LAT=1 instance: back-to-back fetches every 3 cycles
        t        = cyc;
        if_reqF  = 1'b1;
        if_addrF = 32'h100;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!if_readyF && n < 10);
            checkOutput("fast ready cycle", cyc, t + 2 + 3 * k);
            checkOutput("fast if_rdata", if_rdataF, if_addrF ^ 32'hA5A50000);
            checkOutput("fast mem_ready", {31'b0, mem_readyF}, 32'd0);
            if (k == 2) if_reqF = 1'b0;
            else        if_addrF = if_addrF + 32'd4;
        end
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
